uart_txq: RTL and testbench
===========================

UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 4, giving the log2 of the FIFO depth (16 entries).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port resetq, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port wr, input, 1 bit: push strobe, one byte per cycle when high.
REQ-005 The module SHALL have port wr_data, input, 8 bits: byte to push.
REQ-006 The module SHALL have port flush, input, 1 bit: synchronous clear of the queue.
REQ-007 The module SHALL have port enable, input, 1 bit: permits handing bytes to the transmitter when high.
REQ-008 The module SHALL have port uart_busy, input, 1 bit: busy flag from the downstream byte transmitter.
REQ-009 The module SHALL have port uart_wr, output, 1 bit: start strobe to the transmitter.
REQ-010 The module SHALL have port uart_dat, output, 8 bits: byte presented to the transmitter.
REQ-011 The module SHALL have port full, output, 1 bit: level equals 2^DEPTH_LOG2.
REQ-012 The module SHALL have port empty, output, 1 bit: level equals 0.
REQ-013 The module SHALL have port level, output, DEPTH_LOG2+1 bits: current occupancy.
REQ-014 The module SHALL have port overflow, output, 1 bit: sticky flag for a dropped push.
REQ-015 The module SHALL have port sent, output, 16 bits: count of bytes issued to the transmitter, wrapping.

Function
REQ-016 Storage SHALL be a circular buffer of 2^DEPTH_LOG2 bytes with DEPTH_LOG2-bit read/write pointers that wrap modulo depth, plus a separate level counter.
REQ-017 Issue condition SHALL be issue = enable & ~empty & ~uart_busy & ~flush.
REQ-018 uart_wr SHALL equal issue combinationally; uart_dat SHALL be the entry at the read pointer at all times (don't-care when empty).
REQ-019 On a cycle with issue high, the read pointer SHALL advance by 1 and sent SHALL increment by 1 (16-bit wrap, 0xFFFF -> 0x0000).
REQ-020 The downstream transmitter latches on uart_wr & ~uart_busy and raises uart_busy the following cycle; no additional handshake SHALL be required or generated.
REQ-021 Push accepted = wr & ~full & ~flush; an accepted push SHALL write wr_data at the write pointer and advance the write pointer by 1.
REQ-022 wr while full SHALL be dropped and SHALL set overflow, even if an issue occurs in the same cycle; full is evaluated before that cycle's pop.
REQ-023 Simultaneous accepted push and issue SHALL leave level unchanged; push alone SHALL add 1; issue alone SHALL subtract 1.
REQ-024 There SHALL be no fall-through: a byte pushed in cycle N SHALL be issuable no earlier than cycle N+1.
REQ-025 flush SHALL take priority over push and issue: pointers and level go to 0, overflow clears, sent holds its value, and uart_wr is 0 in that cycle.
REQ-026 A flush SHALL NOT affect a byte already handed to the transmitter.
REQ-027 When enable is low, the queue SHALL hold its contents and continue accepting pushes up to full.
REQ-028 full, empty, level, and overflow SHALL be registered or derived only from registered state, never from wr or flush.

Reset
REQ-029 While resetq is low, the following SHALL hold asynchronously: pointers = 0, level = 0, empty = 1, full = 0, overflow = 0, sent = 0x0000, uart_wr = 0.
REQ-030 Storage contents SHALL NOT require reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued bytes, with no uart_wr pulse until at least one push after reset release.

Verification
REQ-032 Basic ordering: with enable=1 and uart_busy modelled as 10 cycles high after each accepted strobe, push 0x41, 0x42, 0x43 on consecutive cycles -> uart_dat sequence 0x41, 0x42, 0x43; exactly 3 uart_wr pulses; sent=3; final level=0.
REQ-033 Fill and overflow: with enable=0, push 17 bytes 0x00..0x10 -> full=1, level=16, overflow=1; then enable=1 -> bytes 0x00..0x0F emitted in order and 0x10 never emitted.
REQ-034 Concurrent push and pop: with level=16, issue and wr in the same cycle -> push dropped, overflow=1, level=15; with level=5, the same stimulus -> level stays 5.
REQ-035 Flush: with level=7, assert flush together with wr and ~uart_busy -> uart_wr=0 that cycle; next cycle level=0, empty=1, overflow=0, sent unchanged.
REQ-036 Wrap-around: push and drain 40 bytes (0x00..0x27) in bursts of 10 -> output order preserved across pointer wrap; sent=40.
REQ-037 Reset mid-stream: with level=4, pulse resetq low for 1 cycle -> outputs take their reset values immediately; no uart_wr pulse afterwards until a new push.

Source files
------------

// File: rtl/uart_txq.sv
// -----------------------------------------------------------------------------
// uart_txq -- byte queue feeding a downstream UART byte transmitter.
//
// A circular buffer of 2^DEPTH_LOG2 bytes. Bytes go in through a push strobe.
// They are handed to the transmitter one at a time while the queue is enabled
// and the transmitter is idle. Occupancy flags come only from registered state.
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   resetq     in   asynchronous active-low reset
//   wr         in   push strobe, one byte per cycle
//   wr_data    in   [7:0] byte to push
//   flush      in   synchronous clear of the queue (wins over push and issue)
//   enable     in   allows bytes to be handed to the transmitter
//   uart_busy  in   transmitter busy flag
//   uart_wr    out  start strobe to the transmitter (combinational issue)
//   uart_dat   out  [7:0] entry at the read pointer
//   full       out  level == 2^DEPTH_LOG2
//   empty      out  level == 0
//   level      out  [DEPTH_LOG2:0] current occupancy
//   overflow   out  sticky flag, set when a push is dropped because full
//   sent       out  [15:0] wrapping count of bytes issued
// -----------------------------------------------------------------------------
module uart_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  wr,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  uart_busy,
  output logic                  uart_wr,
  output logic [7:0]            uart_dat,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           sent
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(32'd0);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(32'd1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(32'd0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic [15:0]           r_sent;

  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic                  w_overflow_nxt;
  logic [15:0]           w_sent_nxt;

  logic w_full;
  logic w_empty;
  logic w_issue;
  logic w_push;

  // Flags come from the registered level only, so full is judged before this
  // cycle's pop: a push into a full queue is dropped even if a byte leaves.
  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == LVL_ZERO);
  assign w_issue = enable & ~w_empty & ~uart_busy & ~flush;
  assign w_push  = wr & ~w_full & ~flush;

  assign uart_wr  = w_issue;
  assign uart_dat = r_mem[r_rd_ptr];
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign sent     = r_sent;

  // Storage write; contents are qualified by level, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Next-state for pointers, level, overflow and the issued-byte counter.
  always_comb begin
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_level_nxt    = r_level;
    w_overflow_nxt = r_overflow;
    w_sent_nxt     = r_sent;
    if (flush) begin
      // sent deliberately keeps its value across a flush
      w_rd_ptr_nxt   = PTR_ZERO;
      w_wr_ptr_nxt   = PTR_ZERO;
      w_level_nxt    = LVL_ZERO;
      w_overflow_nxt = 1'b0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_issue) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        w_sent_nxt   = r_sent + 16'd1;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_sent_nxt   = r_sent;
      end
      if (wr & w_full) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_overflow_nxt = r_overflow;
      end
      case ({w_push, w_issue})
        2'b10:   w_level_nxt = r_level + LVL_ONE;
        2'b01:   w_level_nxt = r_level - LVL_ONE;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rd_ptr   <= PTR_ZERO;
      r_wr_ptr   <= PTR_ZERO;
      r_level    <= LVL_ZERO;
      r_overflow <= 1'b0;
      r_sent     <= 16'd0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_level    <= w_level_nxt;
      r_overflow <= w_overflow_nxt;
      r_sent     <= w_sent_nxt;
    end
  end

endmodule

// File: tb/tb_uart_txq.sv
// -----------------------------------------------------------------------------
// tb_uart_txq -- self-checking bench for uart_txq.
// A queue-based reference model is checked against the DUT on every falling
// edge. Directed scenarios add literal expectations on top of that.
// -----------------------------------------------------------------------------
module tb_uart_txq;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetq;
  logic        wr;
  logic [7:0]  wr_data;
  logic        flush;
  logic        enable;
  logic        uart_busy;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic        full;
  logic        empty;
  logic [DL:0] level;
  logic        overflow;
  logic [15:0] sent;

  uart_txq #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .resetq(resetq), .wr(wr), .wr_data(wr_data), .flush(flush),
    .enable(enable), .uart_busy(uart_busy), .uart_wr(uart_wr),
    .uart_dat(uart_dat), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .sent(sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [15:0] m_sent;
  logic [7:0]  em[$];     // bytes seen on uart_wr
  bit          e_empty, e_full, e_issue;

  // transmitter model control
  bit tx_auto;
  bit busy_force;
  int busy_cnt;
  bit tx_strobe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      @(posedge clk);
      #3;
      if (empty && !uart_busy) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic chk_em(input logic [7:0] start, input int n);
    chk("emit_count", em.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < em.size()) chk($sformatf("emit_%0d", i), 32'(em[i]), 32'(start + 8'(i)));
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      wr_data = start + 8'(i);
      step(1);
    end
    wr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  // Downstream transmitter: busy for 10 cycles after each accepted strobe.
  initial begin
    forever begin
      @(negedge clk);
      tx_strobe = resetq && uart_wr && !uart_busy;
      @(posedge clk);
      #2;
      if (tx_strobe) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      uart_busy = tx_auto ? (busy_cnt != 0) : busy_force;
    end
  end

  // Every-cycle comparison against the queue model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetq) begin
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_sent", 32'(sent), 32'd0);
        chk("rst_uart_wr", 32'(uart_wr), 32'd0);
        mq.delete();
        m_ovf  = 1'b0;
        m_sent = 16'd0;
      end else begin
        e_empty = (mq.size() == 0);
        e_full  = (mq.size() == DEPTH);
        e_issue = enable && !e_empty && !uart_busy && !flush;
        chk("level", 32'(level), mq.size());
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(e_full));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sent", 32'(sent), 32'(m_sent));
        chk("uart_wr", 32'(uart_wr), 32'(e_issue));
        if (!e_empty) chk("uart_dat", 32'(uart_dat), 32'(mq[0]));
        if (uart_wr) em.push_back(uart_dat);
        if (flush) begin
          mq.delete();
          m_ovf = 1'b0;
        end else begin
          if (wr && e_full) m_ovf = 1'b1;
          if (e_issue) begin
            void'(mq.pop_front());
            m_sent = m_sent + 16'd1;
          end
          if (wr && !e_full) mq.push_back(wr_data);
        end
      end
    end
  end

  logic [15:0] sent_hold;

  initial begin
    resetq = 1'b0; wr = 1'b0; wr_data = 8'h00; flush = 1'b0; enable = 1'b0;
    uart_busy = 1'b0; tx_auto = 1'b1; busy_force = 1'b0; busy_cnt = 0;
    step(3);
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_level", 32'(level), 32'd0);
    resetq = 1'b1;
    step(1);

    // basic ordering
    em.delete();
    enable = 1'b1;
    push_seq(8'h41, 3);
    wait_drain(200);
    chk_em(8'h41, 3);
    chk("order_sent", 32'(sent), 32'd3);
    chk("order_level", 32'(level), 32'd0);

    // wrap-around, starting from a fresh reset so sent counts from zero
    resetq = 1'b0;
    step(2);
    resetq = 1'b1;
    step(1);
    em.delete();
    enable = 1'b1;
    for (int b = 0; b < 4; b++) begin
      push_seq(8'(b * 10), 10);
      wait_drain(300);
    end
    chk_em(8'h00, 40);
    chk("wrap_sent", 32'(sent), 32'd40);

    // fill and overflow with issue disabled
    enable = 1'b0;
    do_flush();
    em.delete();
    push_seq(8'h00, 17);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'd1);
    enable = 1'b1;
    wait_drain(400);
    chk_em(8'h00, 16);
    enable = 1'b0;

    // concurrent push and issue while full: push dropped
    tx_auto = 1'b0;
    busy_force = 1'b0;
    do_flush();
    push_seq(8'h80, 16);
    chk("cc_full_pre_level", 32'(level), 32'd16);
    chk("cc_full_pre_ovf", 32'(overflow), 32'd0);
    em.delete();
    enable = 1'b1; wr = 1'b1; wr_data = 8'hEE;
    step(1);
    enable = 1'b0; wr = 1'b0;
    chk("cc_full_level", 32'(level), 32'd15);
    chk("cc_full_ovf", 32'(overflow), 32'd1);
    chk_em(8'h80, 1);

    // drain 8 to reach level 7 with overflow still set, then flush
    enable = 1'b1;
    step(8);
    enable = 1'b0;
    chk("fl_pre_level", 32'(level), 32'd7);
    chk("fl_pre_ovf", 32'(overflow), 32'd1);
    sent_hold = sent;
    enable = 1'b1; wr = 1'b1; wr_data = 8'h33; flush = 1'b1;
    @(negedge clk);
    #1;
    chk("fl_uart_wr", 32'(uart_wr), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; wr = 1'b0; enable = 1'b0;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_sent", 32'(sent), 32'(sent_hold));

    // concurrent push and issue at level 5: level unchanged
    push_seq(8'h10, 5);
    enable = 1'b1; wr = 1'b1; wr_data = 8'h99;
    step(1);
    enable = 1'b0; wr = 1'b0;
    chk("cc_mid_level", 32'(level), 32'd5);
    chk("cc_mid_ovf", 32'(overflow), 32'd0);

    // reset mid-stream at level 4
    tx_auto = 1'b1;
    do_flush();
    push_seq(8'h60, 4);
    chk("rs_pre_level", 32'(level), 32'd4);
    resetq = 1'b0;
    #1;
    chk("rs_level", 32'(level), 32'd0);
    chk("rs_empty", 32'(empty), 32'd1);
    chk("rs_full", 32'(full), 32'd0);
    chk("rs_ovf", 32'(overflow), 32'd0);
    chk("rs_sent", 32'(sent), 32'd0);
    chk("rs_uart_wr", 32'(uart_wr), 32'd0);
    step(1);
    resetq = 1'b1;
    em.delete();
    enable = 1'b1;
    step(20);
    chk("rs_no_emit", em.size(), 32'd0);
    push_seq(8'h5A, 1);
    wait_drain(200);
    chk_em(8'h5A, 1);
    chk("rs_sent_after", 32'(sent), 32'd1);
    enable = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 expected finish earlier");
    $fatal(1);
  end

endmodule
